mem_lane_merger: RTL

Merges the extended-MEM output streams of NUM_LANES parallel read-MEM engines into one AXI4-Stream toward the downstream chaining/writeback logic. Each lane is buffered in its own FIFO. Whole reads (packets delimited by tlast) are granted round-robin, so MEMs of different reads never interleave on the output. Each output beat is tagged with its source lane.

---
 rtl/mem_lane_merger_pkg.sv | 24 ++
 rtl/mem_lane_merger_fifo.sv | 69 ++++++
 rtl/mem_lane_merger.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_lane_merger_pkg.sv
// Shared types for the read-MEM lane merger: the extended-MEM payload,
// the per-lane buffered beat layout and the arbiter state encoding.
package BwaMemDefines;

    // One extended MEM produced by a read-MEM engine.
    typedef struct packed {
        logic [31:0] ref_pos;
        logic [15:0] qbeg;
        logic [15:0] qend;
    } AssemMem;

    // Beat as stored in a lane FIFO: payload with its end-of-read marker in the LSB.
    typedef struct packed {
        AssemMem data;
        logic    last;
    } MergeBeat;

    // Arbiter states: scanning for a lane, or locked onto one lane until its tlast.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_lane_merger_fifo.sv
// mem_lane_fifo: synchronous FIFO with registered full/empty flags.
// A full FIFO refuses a write even when it is popped in the same cycle,
// and an empty FIFO never forwards the write data straight to rdata.
module mem_lane_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_count_nxt;

    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;
    assign rdata     = r_mem[r_rd_ptr];
    assign full      = r_full;
    assign empty     = r_empty;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are flushed logically by the pointer reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule

// File: rtl/mem_lane_merger.sv
// mem_lane_merger: merges NUM_LANES read-MEM streams into one AXI4-Stream.
// Whole reads (tlast-delimited) are granted round-robin so MEMs of different
// reads never interleave; m_tdest carries the source lane of each beat.
// Optional statistics counters are built when MEM_MERGE_STATS_EN is defined.
//
// Handshakes: a beat transfers on a rising edge where valid && ready. A source
// holding valid keeps its data stable until ready; m_tdata/m_tlast/m_tdest
// stay stable while m_tvalid && !m_tready. s_tready is a registered !full.
module mem_lane_merger
    import BwaMemDefines::*;
#(
    parameter int  NUM_LANES  = 4,
    parameter int  DW         = $bits(AssemMem),
    parameter int  FIFO_DEPTH = 16,
    parameter int  CNT_W      = 32,
    localparam int LANE_W     = $clog2(NUM_LANES)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_LANES-1:0][DW-1:0]   s_tdata,
    input  logic [NUM_LANES-1:0]           s_tvalid,
    input  logic [NUM_LANES-1:0]           s_tlast,
    output logic [NUM_LANES-1:0]           s_tready,
    output logic [DW-1:0]                  m_tdata,
    output logic [LANE_W-1:0]              m_tdest,
    output logic                           m_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
`ifdef MEM_MERGE_STATS_EN
    input  logic                           stats_clr,
    output logic [NUM_LANES-1:0][CNT_W-1:0] beat_cnt,
    output logic [NUM_LANES-1:0][CNT_W-1:0] read_cnt,
`endif
    output arb_state_e                     o_dbg_state
);
    // Reject configurations the design is not built for.
    if (NUM_LANES < 2 || NUM_LANES > 16 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_cfg_check
        $error("mem_lane_merger: unsupported parameter set");
    end

    arb_state_e                  r_state;
    arb_state_e                  w_state_nxt;
    logic [LANE_W-1:0]           r_rr_ptr;
    logic [LANE_W-1:0]           w_rr_nxt;
    logic [NUM_LANES-1:0]        w_full;
    logic [NUM_LANES-1:0]        w_empty;
    logic [NUM_LANES-1:0]        w_push;
    logic [NUM_LANES-1:0]        w_pop;
    logic [NUM_LANES-1:0][DW:0]  w_rdata;
    logic [DW:0]                 w_head;
    logic                        w_found;
    logic [LANE_W-1:0]           w_scan_grant;
    int                          w_scan_idx;
    logic                        w_load;
    logic [DW-1:0]               r_m_tdata;
    logic [LANE_W-1:0]           r_m_tdest;
    logic                        r_m_tlast;
    logic                        r_m_tvalid;

    assign s_tready = ~w_full;
    assign w_push   = s_tvalid & ~w_full;
    // While locked, r_rr_ptr is the granted lane.
    assign w_head   = w_rdata[r_rr_ptr];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mem_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DW + 1)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (w_push[l]),
            .wdata   ({s_tdata[l], s_tlast[l]}),
            .pop     (w_pop[l]),
            .rdata   (w_rdata[l]),
            .full    (w_full[l]),
            .empty   (w_empty[l])
        );
    end

    // Round-robin scan: first non-empty lane starting after the last grant.
    always_comb begin
        w_found      = 1'b0;
        w_scan_grant = r_rr_ptr;
        w_scan_idx   = 0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            w_scan_idx = (int'(r_rr_ptr) + i) % NUM_LANES;
            if (!w_found && !w_empty[w_scan_idx]) begin
                w_found      = 1'b1;
                w_scan_grant = LANE_W'(w_scan_idx);
            end
        end
    end

    // Arbiter next state and lane pop; a read holds the lock through empty gaps.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_load      = 1'b0;
        w_pop       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_LOCK;
                    w_rr_nxt    = w_scan_grant;
                end
            end
            S_LOCK: begin
                if ((!r_m_tvalid || m_tready) && !w_empty[r_rr_ptr]) begin
                    w_load          = 1'b1;
                    w_pop[r_rr_ptr] = 1'b1;
                    if (w_head[0]) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Arbiter state register; lane 0 is scanned first after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= LANE_W'(NUM_LANES - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Output register: loads the granted head, holds while stalled, drops valid when drained.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdest  <= '0;
            r_m_tdata  <= '0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_head[DW:1];
            r_m_tlast  <= w_head[0];
            r_m_tdest  <= r_rr_ptr;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_tdata     = r_m_tdata;
    assign m_tdest     = r_m_tdest;
    assign m_tlast     = r_m_tlast;
    assign m_tvalid    = r_m_tvalid;
    assign o_dbg_state = r_state;

`ifdef MEM_MERGE_STATS_EN
    logic [NUM_LANES-1:0][CNT_W-1:0] r_beat_cnt;
    logic [NUM_LANES-1:0][CNT_W-1:0] r_read_cnt;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_stats
        logic w_read_done;
        assign w_read_done = r_m_tvalid && m_tready && r_m_tlast &&
                             (r_m_tdest == LANE_W'(l));

        // Saturating per-lane counters; a clear beats a same-cycle increment.
        always_ff @(posedge clk) begin
            if (!reset_n || stats_clr) begin
                r_beat_cnt[l] <= '0;
                r_read_cnt[l] <= '0;
            end else begin
                if (w_push[l] && (r_beat_cnt[l] != '1))
                    r_beat_cnt[l] <= r_beat_cnt[l] + CNT_W'(1);
                if (w_read_done && (r_read_cnt[l] != '1))
                    r_read_cnt[l] <= r_read_cnt[l] + CNT_W'(1);
            end
        end
    end

    assign beat_cnt = r_beat_cnt;
    assign read_cnt = r_read_cnt;
`endif

endmodule
